contador_bcd_n: RTL and testbench
=================================

CONTADOR_BCD_N -- requirements
Module: contador_bcd_n

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD digits; legal range 1..8.
REQ-002 Parameter WRAP, default 0: 0 = saturate at limits, 1 = wrap around.
REQ-003 Parameter RELOAD_VALUE, default 'h25 (BCD, 4*DIGITS bits): value loaded by auto-reload.
REQ-004 Parameter THRESHOLD, default 'h05 (BCD): auto-reload fires when count < THRESHOLD.
REQ-005 Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  step enable.
- inc  in  1  direction: 1 = up, 0 = down.
- auto_repor  in  1  auto-reload enable.
- reset_no_max  in  1  clear to zero on a step taken while count is at max.
- load  in  1  parallel load strobe.
- load_value  in  4*DIGITS  BCD value to load.
- count  out  4*DIGITS  BCD count; digit 0 = least-significant nibble.
- at_max  out  1  count equals all-9s.
- at_zero  out  1  count equals 0.
- limite  out  1  one-cycle pulse marking a boundary hit.
REQ-006 Clocking and reset are fixed: one clock, and reset is synchronous and active-high (ports named clock and reset).

Function
REQ-007 count is a register updated only on the rising edge of clock; no gated or derived clocks are used.
REQ-008 At each edge the first matching row applies, in this priority order:
- reset: count = 0.
- load: count = load_value, each digit > 9 clamped to 9; load does not require en.
- en & auto_repor & (count < THRESHOLD): count = RELOAD_VALUE.
- en & reset_no_max & at_max: count = 0.
- en & inc: count + 1 in decimal.
- en & ~inc: count - 1 in decimal.
- otherwise: hold.
REQ-009 Increment: a digit at 9 becomes 0 and carries into the next digit; all other digits are unchanged.
REQ-010 Decrement: a digit at 0 becomes 9 and borrows from the next digit.
REQ-011 Increment at max:
- WRAP=0: count holds at max.
- WRAP=1: count becomes 0.
REQ-012 Decrement at 0:
- WRAP=0: count holds at 0.
- WRAP=1: count becomes max.
REQ-013 at_max and at_zero are decoded combinationally from the count register, with zero latency relative to count.
REQ-014 limite is registered, reset to 0, and asserted for exactly the one cycle after any edge on which an en step was attempted at a limit (wrapped or blocked), including a reset_no_max clear.
REQ-015 Comparison with THRESHOLD is an unsigned BCD magnitude comparison over all digits.
REQ-016 A load on the same edge as en has no step effect; limite stays 0 for that edge.
REQ-017 The count never holds a non-BCD digit in any reachable state.

Reset
REQ-018 On reset=1 at an edge: count = 0 and limite = 0; at_max = 0 and at_zero = 1 follow from count.
REQ-019 Reset applied mid-count overrides load, en and auto_repor on that edge.
REQ-020 Counting resumes on the first edge with reset=0.

Structure
REQ-021 Shared package contador_pkg holds:
- BCD digit width constant (4).
- BCD max digit constant (9).
- Per-digit step result typedef {digit, carry_out}.
REQ-022 One sub-module, digito_bcd: a combinational single-digit up/down step with carry-in/borrow-in and carry-out/borrow-out.
REQ-023 The top level instantiates DIGITS copies of digito_bcd in a ripple chain and owns all registers.

Verification
REQ-024 DIGITS=2, WRAP=0: reset, then 101 edges with en=1, inc=1 -> count steps 00..99 and then holds 99, with at_max=1 and limite=1 for the cycle after the blocked step.
REQ-025 Load 'h12, then 3 edges with en=1, inc=0 -> 11, 10, 09; at_zero stays 0.
REQ-026 WRAP=1: at 99, one increment -> 00 with a limite pulse; then one decrement -> 99 with a limite pulse.
REQ-027 auto_repor=1, load 'h06, then decrements -> 05, then 04 (05 is not below THRESHOLD), then 25 on the next edge.
REQ-028 Load 'h3C -> 39 (digit clamp); load together with reset -> 00; reset_no_max=1 at 99 with inc -> 00 with a limite pulse.
REQ-029 DIGITS=3: load 'h199, one increment -> 200; load 'h000, one decrement with WRAP=0 -> holds 000.

Source files
------------

// File: rtl/contador_bcd_n_pkg.sv
// Shared constants and types for the N-digit BCD counter.
// One digit step yields a digit plus a carry/borrow out.
package contador_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef struct packed {
    logic [DIGIT_W-1:0] digit;
    logic               carry;
  } step_t;

  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] d
  );
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/contador_bcd_n_if.sv
// Control and status bundle of the BCD counter.
// master drives the controls, slave is the counter.
interface contador_bcd_n_if #(
  parameter int DIGITS = 2
);

  logic                  en;
  logic                  inc;
  logic                  auto_repor;
  logic                  reset_no_max;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   count;
  logic                  at_max;
  logic                  at_zero;
  logic                  limite;

  modport master (
    output en, inc, auto_repor, reset_no_max,
    output load, load_value,
    input  count, at_max, at_zero, limite
  );

  modport slave (
    input  en, inc, auto_repor, reset_no_max,
    input  load, load_value,
    output count, at_max, at_zero, limite
  );

endinterface

// File: rtl/contador_bcd_n_digito_bcd.sv
// Combinational single BCD digit up/down step.
// cin is the carry (up) or borrow (down) coming from below.
module digito_bcd
  import contador_pkg::*;
(
  input  logic               up,
  input  logic               cin,
  input  logic [DIGIT_W-1:0] digit,
  output step_t              res
);

  always_comb begin
    res.digit = digit;
    res.carry = 1'b0;
    if (cin) begin
      if (up) begin
        if (digit == DIGIT_MAX) begin
          res.digit = '0;
          res.carry = 1'b1;
        end else begin
          res.digit = digit + 4'd1;
        end
      end else begin
        if (digit == '0) begin
          res.digit = DIGIT_MAX;
          res.carry = 1'b1;
        end else begin
          res.digit = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/contador_bcd_n.sv
// N-digit BCD up/down counter with load, auto-reload and
// saturate/wrap limits; digits ripple through digito_bcd.
module contador_bcd_n
  import contador_pkg::*;
#(
  parameter int                  DIGITS       = 2,
  parameter int                  WRAP         = 0,
  parameter logic [4*DIGITS-1:0] RELOAD_VALUE = 'h25,
  parameter logic [4*DIGITS-1:0] THRESHOLD    = 'h05
) (
  input logic               clock,
  input logic               reset,
  contador_bcd_n_if.slave   bus
);

  localparam int W = DIGIT_W * DIGITS;
  localparam logic [W-1:0] MAX_BCD = {DIGITS{DIGIT_MAX}};

  logic [W-1:0]    cnt_q;
  logic            lim_q;
  logic [W-1:0]    nxt;
  logic [W-1:0]    ld_clamp;
  logic [DIGITS:0] carry;
  step_t           st [DIGITS];
  logic            at_max;
  logic            below;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    digito_bcd u_dig (
      .up    (bus.inc),
      .cin   (carry[i]),
      .digit (cnt_q[DIGIT_W*i +: DIGIT_W]),
      .res   (st[i])
    );
    assign nxt[DIGIT_W*i +: DIGIT_W] = st[i].digit;
    assign carry[i+1] = st[i].carry;
    assign ld_clamp[DIGIT_W*i +: DIGIT_W] =
      clamp_digit(bus.load_value[DIGIT_W*i +: DIGIT_W]);
  end

  assign at_max = (cnt_q == MAX_BCD);
  // Valid BCD orders like plain binary, so a vector compare suffices.
  assign below  = (cnt_q < THRESHOLD);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      lim_q <= 1'b0;
    end else begin
      lim_q <= 1'b0;
      if (bus.load) begin
        cnt_q <= ld_clamp;
      end else if (bus.en) begin
        if (bus.auto_repor && below) begin
          cnt_q <= RELOAD_VALUE;
        end else if (bus.reset_no_max && at_max) begin
          cnt_q <= '0;
          lim_q <= 1'b1;
        end else begin
          // Carry out of the top digit means a limit was hit.
          lim_q <= carry[DIGITS];
          if (!carry[DIGITS] || WRAP != 0) begin
            cnt_q <= nxt;
          end
        end
      end
    end
  end

  assign bus.count   = cnt_q;
  assign bus.at_max  = at_max;
  assign bus.at_zero = (cnt_q == '0);
  assign bus.limite  = lim_q;

endmodule

// File: tb/tb_contador_bcd_n.sv
// Bench: three counters share stimulus; a decimal model feeds a
// scoreboard that is checked after every edge.
module tb_contador_bcd_n;

  typedef struct {
    int          dut;
    logic [31:0] cnt;
    bit          mx;
    bit          zr;
    bit          lim;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  contador_bcd_n_if #(.DIGITS(2)) i0 ();
  contador_bcd_n_if #(.DIGITS(2)) i1 ();
  contador_bcd_n_if #(.DIGITS(3)) i2 ();

  contador_bcd_n #(.DIGITS(2), .WRAP(0), .RELOAD_VALUE('h25),
    .THRESHOLD('h05)) u0 (.clock(clock), .reset(reset), .bus(i0));
  contador_bcd_n #(.DIGITS(2), .WRAP(1), .RELOAD_VALUE('h25),
    .THRESHOLD('h05)) u1 (.clock(clock), .reset(reset), .bus(i1));
  contador_bcd_n #(.DIGITS(3), .WRAP(0), .RELOAD_VALUE('h025),
    .THRESHOLD('h005)) u2 (.clock(clock), .reset(reset), .bus(i2));

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  int   m  [3];
  int   nd [3] = '{2, 2, 3};
  int   wr [3] = '{0, 1, 0};
  exp_t sb [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] b = '0;
    for (int i = 0; i < 8; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  function automatic int clamp_val(input logic [31:0] lv, input int n);
    int r = 0;
    int nib;
    for (int i = n - 1; i >= 0; i--) begin
      nib = int'(lv[4*i +: 4]);
      if (nib > 9) nib = 9;
      r = r * 10 + nib;
    end
    return r;
  endfunction

  task automatic predict(input int d, input bit r, input bit ld,
                         input logic [31:0] lv, input bit e,
                         input bit up, input bit ar, input bit rnm);
    int mx = pow10(nd[d]) - 1;
    int v  = m[d];
    int nv = v;
    bit l  = 1'b0;
    if (r) nv = 0;
    else if (ld) nv = clamp_val(lv, nd[d]);
    else if (e && ar && v < 5) nv = 25;
    else if (e && rnm && v == mx) begin nv = 0; l = 1'b1; end
    else if (e && up) begin
      if (v == mx) begin l = 1'b1; nv = wr[d] ? 0 : mx; end
      else nv = v + 1;
    end else if (e) begin
      if (v == 0) begin l = 1'b1; nv = wr[d] ? mx : 0; end
      else nv = v - 1;
    end
    m[d] = nv;
    sb.push_back('{d, to_bcd(nv), nv == mx, nv == 0, l});
  endtask

  task automatic check_out(input exp_t x);
    logic [31:0] c;
    bit mx, zr, lm;
    string p;
    case (x.dut)
      0: begin c = 32'(i0.count); mx = i0.at_max;
               zr = i0.at_zero; lm = i0.limite; end
      1: begin c = 32'(i1.count); mx = i1.at_max;
               zr = i1.at_zero; lm = i1.limite; end
      default: begin c = 32'(i2.count); mx = i2.at_max;
               zr = i2.at_zero; lm = i2.limite; end
    endcase
    p = $sformatf("u%0d", x.dut);
    chk({p, ".count"}, c, x.cnt);
    chk({p, ".at_max"}, 32'(mx), 32'(x.mx));
    chk({p, ".at_zero"}, 32'(zr), 32'(x.zr));
    chk({p, ".limite"}, 32'(lm), 32'(x.lim));
  endtask

  task automatic step(input bit r, input bit ld,
                      input logic [31:0] lv, input bit e,
                      input bit up, input bit ar, input bit rnm);
    reset = r;
    i0.load = ld; i1.load = ld; i2.load = ld;
    i0.load_value = lv[7:0];
    i1.load_value = lv[7:0];
    i2.load_value = lv[11:0];
    i0.en = e; i1.en = e; i2.en = e;
    i0.inc = up; i1.inc = up; i2.inc = up;
    i0.auto_repor = ar; i1.auto_repor = ar; i2.auto_repor = ar;
    i0.reset_no_max = rnm; i1.reset_no_max = rnm;
    i2.reset_no_max = rnm;
    for (int d = 0; d < 3; d++) predict(d, r, ld, lv, e, up, ar, rnm);
    @(posedge clock);
    #1;
    while (sb.size() > 0) check_out(sb.pop_front());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    // Count up through max and into the saturation/wrap region.
    for (int k = 0; k < 101; k++) step(0, 0, 0, 1, 1, 0, 0);
    idle();
    step(0, 1, 'h12, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 'h99, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 'h06, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0, 1, 0);
    step(0, 1, 'h3C, 0, 0, 0, 0);
    step(1, 1, 'h77, 1, 1, 1, 0);
    step(0, 1, 'h99, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 1);
    step(0, 1, 'h199, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 'h000, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    // Load beside an enabled step at a limit: load wins, no pulse.
    step(0, 1, 'h999, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 'hFAF, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 'h45, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 'h33, 1, 1, 1, 1);
    step(0, 0, 0, 1, 1, 0, 0);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
